esm_issue_scheduler: RTL and testbench

Issue/retire end of the ESM dependency path. Owns the bs-entry instruction buffer.
- Allocates slots and drives buffer_index into the dependency core.
- Consumes the core's ready_positions and issues the oldest ready instruction to execution.
- Tracks completions and retires slots in program order.
- Emits a retire pulse so the dependency tables can be cleared.

---
 rtl/esm_issue_scheduler.sv | 116 +++++++++++
 tb/tb_esm_issue_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/esm_issue_scheduler.sv
// Issue/retire end of the ESM dependency path: slot allocation, oldest-ready issue, in-order retire.
// Optional ESM_ISSUE_STALL_CNT_EN adds a saturating stall_cycles counter output.
module esm_issue_scheduler #(
  parameter int unsigned bs = 16,
  localparam int unsigned IW = $clog2(bs)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_valid,
  output logic          alloc_ready,
  output logic [IW-1:0] buffer_index,
  input  logic [bs-1:0] ready_positions,
  output logic          issue_valid,
  input  logic          issue_ready,
  output logic [IW-1:0] issue_index,
  input  logic          cmpl_valid,
  input  logic [IW-1:0] cmpl_index,
  output logic          retire_valid,
  output logic [IW-1:0] retire_index,
  output logic [IW:0]   occupancy,
  output logic          cmpl_err
`ifdef ESM_ISSUE_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cycles
`endif
);

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] ISSUED = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;
  localparam logic [IW:0] FULL_CNT = (IW+1)'(bs);

  logic [1:0]    slot_q [bs];
  logic [1:0]    slot_d [bs];
  logic [IW-1:0] head_q, tail_q;
  logic [IW:0]   count_q, count_d;

  logic          alloc_fire, issue_fire, cmpl_ok, retire_fire;
  logic          found;
  logic [IW-1:0] sel, scan_idx;

  assign alloc_ready  = (count_q != FULL_CNT);
  assign buffer_index = tail_q;
  assign occupancy    = count_q;
  assign issue_valid  = found;
  assign issue_index  = sel;

  assign alloc_fire  = alloc_valid && alloc_ready;
  assign issue_fire  = found && issue_ready;
  assign cmpl_ok     = cmpl_valid && (slot_q[cmpl_index] == ISSUED);
  assign retire_fire = (count_q != '0) && (slot_q[head_q] == DONE);

  // Age-ordered scan starting at head; index arithmetic wraps naturally.
  always_comb begin : issue_scan
    found    = 1'b0;
    sel      = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < bs; i++) begin
      scan_idx = head_q + IW'(i);
      if (!found && (slot_q[scan_idx] == WAIT) && ready_positions[scan_idx]) begin
        found = 1'b1;
        sel   = scan_idx;
      end
    end
  end

  // Per-slot next state; the four events can never target the same slot.
  always_comb begin : next_state
    slot_d = slot_q;
    if (alloc_fire)  slot_d[tail_q]     = WAIT;
    if (issue_fire)  slot_d[sel]        = ISSUED;
    if (cmpl_ok)     slot_d[cmpl_index] = DONE;
    if (retire_fire) slot_d[head_q]     = FREE;
    count_d = count_q;
    case ({alloc_fire, retire_fire})
      2'b10:   count_d = count_q + (IW+1)'(1);
      2'b01:   count_d = count_q - (IW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < bs; i++) slot_q[i] <= FREE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      retire_valid <= 1'b0;
      retire_index <= '0;
      cmpl_err     <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      count_q      <= count_d;
      retire_valid <= retire_fire;
      if (alloc_fire)  tail_q <= tail_q + IW'(1);
      if (retire_fire) begin
        head_q       <= head_q + IW'(1);
        retire_index <= head_q;
      end
      if (cmpl_valid && !cmpl_ok) cmpl_err <= 1'b1;
    end
  end

`ifdef ESM_ISSUE_STALL_CNT_EN
  // Cycles with work in flight but nothing issued; saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if ((count_q != '0) && !issue_fire && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_esm_issue_scheduler.sv
// Bench for esm_issue_scheduler: directed scenarios plus random traffic against a program-order queue model.
module tb_esm_issue_scheduler;
  localparam int unsigned BS = 16;
  localparam int unsigned IW = $clog2(BS);
  localparam int ST_W = 1, ST_I = 2, ST_D = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid, alloc_ready;
  logic [IW-1:0] buffer_index;
  logic [BS-1:0] ready_positions;
  logic          issue_valid, issue_ready;
  logic [IW-1:0] issue_index;
  logic          cmpl_valid;
  logic [IW-1:0] cmpl_index;
  logic          retire_valid;
  logic [IW-1:0] retire_index;
  logic [IW:0]   occupancy;
  logic          cmpl_err;
`ifdef ESM_ISSUE_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  esm_issue_scheduler #(.bs(BS)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .buffer_index(buffer_index),
    .ready_positions(ready_positions),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_index(issue_index),
    .cmpl_valid(cmpl_valid), .cmpl_index(cmpl_index),
    .retire_valid(retire_valid), .retire_index(retire_index),
    .occupancy(occupancy), .cmpl_err(cmpl_err)
`ifdef ESM_ISSUE_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: in-flight instructions in program order, each with its slot and state.
  typedef struct { int slot; int st; } ent_t;
  ent_t q[$];
  int   next_slot;
  bit   m_err, m_rv;
  int   m_ri;
  logic [31:0] m_stall;

  task automatic model_reset();
    q.delete();
    next_slot = 0;
    m_err = 0; m_rv = 0; m_ri = 0; m_stall = '0;
  endtask

  int  k, ck;
  bit  rfire, ifire, pre_full;
  logic [IW-1:0] exp_ii;

  // Compare at the falling edge, then advance the model across the coming rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      model_reset();
      chk("rst_alloc_ready", alloc_ready, 1);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_issue_valid", issue_valid, 0);
      chk("rst_retire_valid", retire_valid, 0);
      chk("rst_cmpl_err", cmpl_err, 0);
    end else begin
      k = -1;
      foreach (q[j]) if (k < 0 && q[j].st == ST_W && ready_positions[q[j].slot]) k = j;
      exp_ii = (k >= 0) ? IW'(q[k].slot) : '0;
      chk("alloc_ready", alloc_ready, (q.size() != BS));
      chk("buffer_index", buffer_index, next_slot);
      chk("occupancy", occupancy, q.size());
      chk("issue_valid", issue_valid, (k >= 0));
      chk("issue_index", issue_index, exp_ii);
      chk("retire_valid", retire_valid, m_rv);
      if (m_rv) chk("retire_index", retire_index, m_ri);
      chk("cmpl_err", cmpl_err, m_err);
`ifdef ESM_ISSUE_STALL_CNT_EN
      chk("stall_cycles", stall_cycles, m_stall);
`endif
      rfire = (q.size() > 0) && (q[0].st == ST_D);
      ck = -1;
      foreach (q[j]) if (q[j].slot == int'(cmpl_index) && q[j].st == ST_I) ck = j;
      ifire = (k >= 0) && issue_ready;
      if (q.size() != 0 && !ifire && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (ifire) q[k].st = ST_I;
      if (cmpl_valid) begin
        if (ck >= 0) q[ck].st = ST_D;
        else m_err = 1;
      end
      pre_full = (q.size() == BS);
      m_rv = rfire;
      if (rfire) begin
        m_ri = q[0].slot;
        void'(q.pop_front());
      end
      if (alloc_valid && !pre_full) begin
        q.push_back('{next_slot, ST_W});
        next_slot = (next_slot + 1) % BS;
      end
    end
  end

  task automatic drive(input bit av, input logic [BS-1:0] rp, input bit ir, input bit cv, input int ci);
    @(posedge clk);
    #1;
    alloc_valid = av; ready_positions = rp; issue_ready = ir;
    cmpl_valid = cv; cmpl_index = IW'(ci);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, 0, 0, 0);
  endtask

  // Asynchronous assertion between edges; outputs must clear before any clock.
  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_occupancy", occupancy, 0);
    chk("async_issue_valid", issue_valid, 0);
    chk("async_retire_valid", retire_valid, 0);
    alloc_valid = 0; ready_positions = '0; issue_ready = 0; cmpl_valid = 0; cmpl_index = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  int  issued[$];
  bit  r_av, r_ir, r_cv;
  logic [BS-1:0] r_rp;
  int  r_ci;

  initial begin
    rst = 1'b0;
    alloc_valid = 0; ready_positions = '0; issue_ready = 0; cmpl_valid = 0; cmpl_index = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("lit_reset_alloc_ready", alloc_ready, 1);
    chk("lit_reset_buffer_index", buffer_index, 0);
    chk("lit_reset_retire_index", retire_index, 0);

    // Alloc three with everything ready: issues follow one cycle behind.
    drive(1, 16'hFFFF, 1, 0, 0); chk("lit_bidx0", buffer_index, 0); chk("lit_iv_empty", issue_valid, 0);
    drive(1, 16'hFFFF, 1, 0, 0); chk("lit_bidx1", buffer_index, 1); chk("lit_issue0", issue_index, 0);
    drive(1, 16'hFFFF, 1, 0, 0); chk("lit_bidx2", buffer_index, 2); chk("lit_issue1", issue_index, 1);
    drive(0, 16'hFFFF, 1, 0, 0); chk("lit_issue2", issue_index, 2); chk("lit_occ3", occupancy, 3);

    // Ready-driven selection, out-of-order completion, in-order retire.
    pulse_reset();
    repeat (3) drive(1, '0, 1, 0, 0);
    drive(0, 16'h0004, 1, 0, 0); chk("lit_sel2", issue_index, 2);
    drive(0, 16'h0007, 1, 0, 0); chk("lit_sel0", issue_index, 0);
    drive(0, 16'h0007, 1, 0, 0); chk("lit_sel1", issue_index, 1);
    drive(0, '0, 1, 1, 2);
    drive(0, '0, 1, 1, 1);
    drive(0, '0, 1, 1, 0);
    drive(0, '0, 0, 0, 0); chk("lit_no_retire_yet", retire_valid, 0);
    drive(0, '0, 0, 0, 0); chk("lit_ret0_v", retire_valid, 1); chk("lit_ret0_i", retire_index, 0);
    drive(0, '0, 0, 0, 0); chk("lit_ret1_i", retire_index, 1);
    drive(0, '0, 0, 0, 0); chk("lit_ret2_i", retire_index, 2); chk("lit_occ0", occupancy, 0);

    // Full buffer, then free slot 0 and reuse it.
    pulse_reset();
    repeat (16) drive(1, '0, 0, 0, 0);
    drive(1, 16'h0001, 1, 0, 0); chk("lit_full_ar", alloc_ready, 0); chk("lit_full_occ", occupancy, 16);
    drive(1, '0, 0, 1, 0); chk("lit_full_ar2", alloc_ready, 0);
    drive(1, '0, 0, 0, 0); chk("lit_full_ar_retire_cycle", alloc_ready, 0);
    drive(1, '0, 0, 0, 0); chk("lit_wrap_ret", retire_index, 0); chk("lit_wrap_ar", alloc_ready, 1);
    chk("lit_wrap_bidx", buffer_index, 0);
    drive(0, '0, 0, 0, 0); chk("lit_wrap_bidx1", buffer_index, 1); chk("lit_wrap_occ", occupancy, 16);

    // Move head to 14, then check age order across the wrap.
    pulse_reset();
    repeat (14) drive(1, '0, 0, 0, 0);
    for (int i = 0; i <= 14; i++) drive(0, 16'hFFFF, 1, (i > 0), i - 1);
    idle(16);
    repeat (3) drive(1, '0, 0, 0, 0);
    drive(0, 16'h8001, 0, 0, 0); chk("lit_wrap_age", issue_index, 15); chk("lit_wrap_age_occ", occupancy, 3);

    // Completion of a FREE slot is sticky.
    pulse_reset();
    drive(0, '0, 0, 1, 5); chk("lit_err_before", cmpl_err, 0);
    drive(0, '0, 0, 0, 0); chk("lit_err_set", cmpl_err, 1);
    idle(3);                chk("lit_err_sticky", cmpl_err, 1);

    // Reset with work in flight.
    pulse_reset();
    repeat (5) drive(1, 16'hFFFF, 0, 0, 0);
    pulse_reset();

`ifdef ESM_ISSUE_STALL_CNT_EN
    pulse_reset();
    drive(1, '0, 0, 0, 0);
    repeat (5) drive(0, '0, 0, 0, 0);
    chk("lit_stall4", stall_cycles, 4);
`endif

    // Random traffic; completions mostly target issued slots.
    for (int n = 0; n < 3000; n++) begin
      issued.delete();
      foreach (q[j]) if (q[j].st == ST_I) issued.push_back(q[j].slot);
      r_av = ($urandom_range(0, 3) != 0);
      r_rp = ($urandom_range(0, 4) == 0) ? {BS{1'b1}} : BS'($urandom);
      r_ir = ($urandom_range(0, 3) != 0);
      r_cv = 0;
      r_ci = $urandom_range(0, BS - 1);
      if (issued.size() > 0 && $urandom_range(0, 2) != 0) begin
        r_cv = 1;
        r_ci = issued[$urandom_range(0, issued.size() - 1)];
      end else if ($urandom_range(0, 39) == 0) begin
        r_cv = 1;
      end
      if (n % 700 == 699) pulse_reset();
      else drive(r_av, r_rp, r_ir, r_cv, r_ci);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
